count_checker: RTL

Receiving end of the free-running count stream driven by the counter producers in the race/no-race examples. It samples one count per accepted beat and compares it with an internally generated expected value. It reports per-beat mismatches, a saturating error total, and a pass/fail verdict after `NUM_TESTS` beats. It replaces the ad-hoc `assert (count1 == count2)` checker process with a reusable, clocked, order-independent block.

---
 rtl/count_checker.sv | 69 ++++++
 1 files changed

// File: rtl/count_checker.sv
// count_checker: checks an incoming count stream against an internal expected sequence
// and reports per-beat mismatches, a saturating error total and a pass/fail verdict.
module count_checker #(
    parameter int WIDTH       = 8,
    parameter int NUM_TESTS   = 100,
    parameter int START_VALUE = 1,
    parameter int RESYNC      = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           in_valid,
    input  logic [WIDTH-1:0]               in_count,
    output logic                           in_ready,
    output logic [WIDTH-1:0]               expected,
    output logic                           mismatch,
    output logic [15:0]                    err_count,
    output logic [$clog2(NUM_TESTS+1)-1:0] beat_count,
    output logic                           done,
    output logic                           pass
);
    localparam int BW = $clog2(NUM_TESTS+1);
    localparam logic [WIDTH-1:0] START = WIDTH'(START_VALUE);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nx;

    logic accept, hit, last, arm;

    assign in_ready = state == RUN;
    assign accept   = in_valid && in_ready;
    assign hit      = in_count == expected;
    assign last     = beat_count == BW'(NUM_TESTS - 1);
    assign arm      = start && state != RUN;
    assign done     = state == DONE;
    assign pass     = done && err_count == 16'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (arm)                 state_nx = RUN;
        else if (accept && last) state_nx = DONE;
    end

    // RESYNC selects whether a bad beat re-seeds the expected sequence
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            expected   <= START;
            mismatch   <= 1'b0;
            err_count  <= 16'd0;
            beat_count <= '0;
        end else begin
            mismatch <= accept && !hit;
            if (arm) begin
                expected   <= START;
                err_count  <= 16'd0;
                beat_count <= '0;
            end else if (accept) begin
                beat_count <= beat_count + BW'(1);
                if (!hit && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
                expected <= (hit || RESYNC == 0) ? expected + WIDTH'(1) : in_count + WIDTH'(1);
            end
        end
    end
endmodule
